// File: rtl/delay_sweep_pkg.sv
// Shared types and width helpers for the delay-chain characterisation block.
package delay_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_CAPT   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    function automatic int tap_idx_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic int err_w(input int taps, input int trials);
        return $clog2(taps * trials + 1);
    endfunction

endpackage

// File: rtl/tapped_delay_line.sv
// Inverter chain with a tap after every PAIRS_PER_TAP inverter pairs.
module tapped_delay_line #(
    parameter int TAPS          = 8,
    parameter int PAIRS_PER_TAP = 2
) (
    input  logic            din,
    output logic [TAPS-1:0] taps
);

    localparam int N_INV = 2 * PAIRS_PER_TAP * TAPS;

    // Each stage owns its nets so the chain is a plain feed-forward structure.
    for (genvar i = 0; i < N_INV; i++) begin : g_inv
        wire n_in;
        wire n_out;
        if (i == 0) begin : g_first
            assign n_in = din;
        end else begin : g_next
            assign n_in = g_inv[i-1].n_out;
        end
        (* keep = "true", dont_touch = "true" *)
        not u_inv (n_out, n_in);
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        assign taps[k] = g_inv[2*PAIRS_PER_TAP*(k+1)-1].n_out;
    end

endmodule

// File: rtl/delay_sweep.sv
// Launch/capture sequencer that characterises a tapped delay chain, one tap or all taps.
module delay_sweep
    import delay_sweep_pkg::*;
#(
    parameter int TAPS          = 8,
    parameter int PAIRS_PER_TAP = 2,
    parameter int TRIALS        = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              sweep,
    input  logic [tap_idx_w(TAPS)-1:0]        tap_sel,
    input  logic                              test,
    input  logic                              inject,
    output logic                              busy,
    output logic                              done,
    output logic                              fail_found,
    output logic [tap_idx_w(TAPS)-1:0]        first_fail_tap,
    output logic [err_w(TAPS, TRIALS)-1:0]    err_cnt,
    output logic                              dout
);

    localparam int TW = tap_idx_w(TAPS);
    localparam int EW = err_w(TAPS, TRIALS);
    localparam int CW = $clog2(TRIALS + 1);
    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);
    localparam logic [CW-1:0] TRIALS_C = CW'(TRIALS);

    state_e          state_q, state_d;
    logic            launch_q, launch_d;
    logic            expect_q, expect_d;
    logic            cap_q, cap_d;
    logic [TW-1:0]   cur_q, cur_d;
    logic [CW-1:0]   trial_q, trial_d;
    logic            tapfail_q, tapfail_d;
    logic [EW-1:0]   err_q, err_d;
    logic            ffound_q, ffound_d;
    logic [TW-1:0]   ftap_q, ftap_d;
    logic            sweep_q, sweep_d;
    logic            test_q, test_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [TAPS-1:0] taps_s;
    logic            tap_s;
    logic            mismatch_s;
    logic [CW-1:0]   trial_inc_s;

    function automatic logic [TW-1:0] clamp_tap(input logic [TW-1:0] sel);
        if (int'(sel) > TAPS - 1) begin
            return LAST_TAP;
        end else begin
            return sel;
        end
    endfunction

    tapped_delay_line #(
        .TAPS          (TAPS),
        .PAIRS_PER_TAP (PAIRS_PER_TAP)
    ) u_line (
        .din  (launch_q),
        .taps (taps_s)
    );

    // The chain is a deliberate single-cycle path: launch_q -> taps -> mux -> cap_q.
    assign tap_s       = taps_s[cur_q];
    assign mismatch_s  = cap_q ^ expect_q;
    assign trial_inc_s = trial_q + CW'(1);

    // Next-state and datapath decode for the launch/capture/check sequence.
    always_comb begin
        state_d   = state_q;
        launch_d  = launch_q;
        expect_d  = expect_q;
        cap_d     = cap_q;
        cur_d     = cur_q;
        trial_d   = trial_q;
        tapfail_d = tapfail_q;
        err_d     = err_q;
        ffound_d  = ffound_q;
        ftap_d    = ftap_q;
        sweep_d   = sweep_q;
        test_d    = test_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sweep_d   = sweep;
                    test_d    = test;
                    cur_d     = sweep ? {TW{1'b0}} : clamp_tap(tap_sel);
                    err_d     = {EW{1'b0}};
                    ffound_d  = 1'b0;
                    ftap_d    = {TW{1'b0}};
                    trial_d   = {CW{1'b0}};
                    tapfail_d = 1'b0;
                    state_d   = S_LAUNCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_LAUNCH: begin
                launch_d = ~launch_q;
                expect_d = ~launch_q;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                cap_d   = (test_q ? tap_s : launch_q) ^ inject;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    tapfail_d = 1'b1;
                    if (err_q != {EW{1'b1}}) begin
                        err_d = err_q + EW'(1);
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    tapfail_d = tapfail_q;
                end
                if (trial_inc_s == TRIALS_C) begin
                    if ((tapfail_q || mismatch_s) && !ffound_q) begin
                        ffound_d = 1'b1;
                        ftap_d   = cur_q;
                    end else begin
                        ffound_d = ffound_q;
                    end
                    trial_d   = {CW{1'b0}};
                    tapfail_d = 1'b0;
                    if (sweep_q && (cur_q != LAST_TAP)) begin
                        cur_d   = cur_q + TW'(1);
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    trial_d = trial_inc_s;
                    state_d = S_LAUNCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_LAUNCH) || (state_d == S_CAPT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // State, counters, launch/capture flops and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            launch_q  <= 1'b0;
            expect_q  <= 1'b0;
            cap_q     <= 1'b0;
            cur_q     <= {TW{1'b0}};
            trial_q   <= {CW{1'b0}};
            tapfail_q <= 1'b0;
            err_q     <= {EW{1'b0}};
            ffound_q  <= 1'b0;
            ftap_q    <= {TW{1'b0}};
            sweep_q   <= 1'b0;
            test_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            launch_q  <= launch_d;
            expect_q  <= expect_d;
            cap_q     <= cap_d;
            cur_q     <= cur_d;
            trial_q   <= trial_d;
            tapfail_q <= tapfail_d;
            err_q     <= err_d;
            ffound_q  <= ffound_d;
            ftap_q    <= ftap_d;
            sweep_q   <= sweep_d;
            test_q    <= test_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign fail_found     = ffound_q;
    assign first_fail_tap = ftap_q;
    assign err_cnt        = err_q;
    assign dout           = cap_q;

endmodule

// File: tb/tb_delay_sweep.sv
// Scoreboard bench for delay_sweep: driver queues expected run results, monitor checks on done.
module tb_delay_sweep;

    localparam int TAPS   = 8;
    localparam int PAIRS  = 2;
    localparam int TRIALS = 4;
    localparam int TW     = 3;
    localparam int EW     = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sweep = 1'b0;
    logic [TW-1:0] tap_sel = '0;
    logic          test = 1'b1;
    logic          inject = 1'b0;
    logic          busy, done, fail_found, dout;
    logic [TW-1:0] first_fail_tap;
    logic [EW-1:0] err_cnt;

    typedef struct {
        int cyc;
        int err;
        int ff;
        int ft;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    delay_sweep #(
        .TAPS          (TAPS),
        .PAIRS_PER_TAP (PAIRS),
        .TRIALS        (TRIALS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sweep          (sweep),
        .tap_sel        (tap_sel),
        .test           (test),
        .inject         (inject),
        .busy           (busy),
        .done           (done),
        .fail_found     (fail_found),
        .first_fail_tap (first_fail_tap),
        .err_cnt        (err_cnt),
        .dout           (dout)
    );

    always #5 clk = ~clk;

    // cyc holds the number of rising edges seen so far.
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("err_cnt", int'(err_cnt), e.err);
                check("fail_found", int'(fail_found), e.ff);
                check("first_fail_tap", int'(first_fail_tap), e.ft);
                check("busy_in_done", int'(busy), 0);
            end
        end
    end

    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic do_start(input bit sw, input logic [TW-1:0] ts, input bit tst, input int n,
                            input int e_err, input int e_ff, input int e_ft, input bit push,
                            output int sc);
        sweep   = sw;
        tap_sel = ts;
        test    = tst;
        start   = 1'b1;
        sc      = cyc;
        if (push) begin
            sb.push_back('{cyc: sc + 1 + 3 * TRIALS * n, err: e_err, ff: e_ff, ft: e_ft});
        end
        @(negedge clk);
        start   = 1'b0;
        sweep   = ~sw;
        tap_sel = ~ts;
        test    = ~tst;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("run_completed", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        int sc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_dout", int'(dout), 0);

        // Reset mid-sweep with errors accumulated; the aborted run must not pulse done.
        inject = 1'b1;
        do_start(1'b1, 3'd0, 1'b1, TAPS, 0, 0, 0, 1'b0, sc);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ff", int'(fail_found), 0);
        check("midrst_ftap", int'(first_fail_tap), 0);
        check("midrst_err", int'(err_cnt), 0);
        check("midrst_dout", int'(dout), 0);
        rst    = 1'b0;
        inject = 1'b0;
        repeat (110) @(negedge clk);

        // Clean sweep: 32 trials, done on the 97th edge counting the start edge.
        do_start(1'b1, 3'd0, 1'b1, TAPS, 0, 0, 0, 1'b1, sc);
        wait_drain(200);

        // Manual tap 5 with inject held high: every trial fails.
        inject = 1'b1;
        do_start(1'b0, 3'd5, 1'b1, 1, 4, 1, 5, 1'b1, sc);
        wait_drain(50);
        inject = 1'b0;

        // Sweep with inject raised only across tap 3 (capture edges 38,41,44,47 after start).
        do_start(1'b1, 3'd0, 1'b1, TAPS, 4, 1, 3, 1'b1, sc);
        while (cyc < sc + 1 + 36) @(negedge clk);
        inject = 1'b1;
        while (cyc < sc + 1 + 47) @(negedge clk);
        inject = 1'b0;
        wait_drain(200);

        // Bypass at the top tap (tap_sel=15 truncates to 7 on a 3-bit port); 68 trials so far, launch is 0.
        do_start(1'b0, 3'd7, 1'b0, 1, 0, 0, 0, 1'b1, sc);
        for (int t = 0; t < TRIALS; t++) begin
            while (cyc < sc + 3 + 3 * t) @(negedge clk);
            check("bypass_dout", int'(dout), (t % 2 == 0) ? 1 : 0);
        end
        wait_drain(50);

        // Handshake: start while busy is ignored; start in the done cycle restarts and clears results.
        inject = 1'b1;
        do_start(1'b0, 3'd2, 1'b1, 1, 4, 1, 2, 1'b1, sc);
        while (cyc < sc + 6) @(negedge clk);
        start = 1'b1;
        sweep = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < sc + 13) @(negedge clk);
        inject = 1'b0;
        check("done_for_restart", int'(done), 1);
        do_start(1'b0, 3'd0, 1'b1, 1, 0, 0, 0, 1'b1, sc);
        check("restart_err_cleared", int'(err_cnt), 0);
        check("restart_ff_cleared", int'(fail_found), 0);
        check("restart_no_done", int'(done), 0);
        wait_drain(50);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_sweep.md
# delay_sweep

Built-in delay-chain characterisation block. A launch flop drives a tapped inverter chain of `TAPS` taps, each `PAIRS_PER_TAP` inverter pairs long, and a capture flop samples one selectable tap every trial. On `start`, a sequencer runs `TRIALS` launch/capture trials either on one tap (manual) or across every tap in ascending order (sweep). It counts mismatches and reports the first tap that failed. The block sits behind the user-project I/O as the successor of the fixed-length test chain, and feeds the scan/readout logic.

## Interface

**Parameters**
- `TAPS`, default 8: number of selectable taps, ≥2.
- `PAIRS_PER_TAP`, default 2: inverter pairs between adjacent taps. Tap k sits after 2·PAIRS_PER_TAP·(k+1) inverters.
- `TRIALS`, default 4: launch/capture trials per tap, ≥1.

**Ports**
- `clk`, in, 1: single clock. Synchronous and active-high reset (`rst`) decided; one clock only.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request. Accepted only in IDLE or DONE.
- `sweep`, in, 1: sampled at accepted `start`. 1 = all taps; 0 = tap `tap_sel` only.
- `tap_sel`, in, TW = $clog2(TAPS): manual tap, sampled at `start`. Values ≥ TAPS clamp to TAPS-1.
- `test`, in, 1: sampled at `start`. 1 = capture from chain tap; 0 = capture directly from launch flop (bypass).
- `inject`, in, 1: self-test. While 1, capture data is inverted before comparison.
- `busy`, out, 1: high from the cycle after accepted `start` until DONE.
- `done`, out, 1: one-cycle pulse on entry to DONE.
- `fail_found`, out, 1: at least one tap recorded a mismatch in the last run.
- `first_fail_tap`, out, TW: lowest failing tap index. 0 if none.
- `err_cnt`, out, EW = $clog2(TAPS·TRIALS+1): total mismatches in the last run. Saturates at all-ones.
- `dout`, out, 1: capture flop value.

## Operation

- **FSM states:** IDLE → LAUNCH → CAPT → CHECK → (LAUNCH | DONE). DONE → LAUNCH on `start`. DONE otherwise holds.
- **Accepted `start`** (IDLE/DONE):
  - Latch `sweep`, `test`, and clamped `tap_sel`.
  - Current tap = 0 if `sweep`, else the clamped `tap_sel`.
  - Clear `err_cnt`, `fail_found`, `first_fail_tap`, trial counter, per-tap fail flag.
  - Go to LAUNCH.
- **LAUNCH:** launch flop toggles. Expected value := new launch value.
- **CAPT:** capture flop loads `(test ? tap[cur] : launch) ^ inject`.
- **CHECK:**
  - If capture ≠ expected: increment `err_cnt` (saturating) and set the per-tap flag.
  - Trial counter +1.
  - If trial counter = TRIALS:
    - If the per-tap flag is set and `fail_found` = 0: set `fail_found` and `first_fail_tap` := cur.
    - Clear the trial counter and per-tap flag.
    - Advance the tap if `sweep` and cur < TAPS-1, else go to DONE.
- **Ignored inputs:** `start` during busy is ignored. Changes to `sweep`/`tap_sel`/`test` mid-run are ignored.
- **`inject`:** sampled live, every CAPT cycle.
- **Launch flop:** never reset by `start`, only by `rst`. Consecutive runs continue alternating.
- **Results:** held stable in DONE until the next accepted `start`.

## Timing

- **Reset** (`rst`=1 at a `clk` edge): state IDLE. `busy`=0, `done`=0, `fail_found`=0, `first_fail_tap`=0, `err_cnt`=0, `dout`=0. Launch flop = 0; counters = 0.
- **Reset mid-run:** abort to IDLE with the values above. No `done` pulse.
- **Trial length:** exactly 3 cycles.
- **Run length:** `done` is asserted 3·TRIALS·N + 1 cycles after the `start` edge, where N = TAPS (sweep) or 1 (manual). `busy` is low in the `done` cycle.
- **Chain path:** combinational, launch flop → tap mux → capture flop. It is a single-cycle path by design. Failures on silicon are real setup violations.
- **`start` in the DONE-pulse cycle:** accepted. `done` still pulses for that one cycle.

## Structure

- **Shared package `delay_sweep_pkg`:** FSM state enum; `tap_idx_w(TAPS)` and `err_w(TAPS,TRIALS)` width helpers.
- **Sub-module `tapped_delay_line`:** parameters `TAPS`, `PAIRS_PER_TAP`; ports `din`, `taps[TAPS-1:0]`.
  - Every inverter is instantiated as a primitive with `keep`/`dont_touch`.
  - The tap mux stays in the top.
- **Top:** FSM, counters, launch/capture flops.

## Test plan

- **Reset:** hold `rst` 2 cycles mid-sweep (TAPS=8, TRIALS=4) → all outputs 0, IDLE, no `done`.
- **Clean sweep:** `sweep`=1, `test`=1, `inject`=0 → `done` at cycle 97. `err_cnt`=0, `fail_found`=0, `first_fail_tap`=0.
- **Manual + inject:** `sweep`=0, `tap_sel`=5, `inject`=1 → `done` at cycle 13. `err_cnt`=4, `fail_found`=1, `first_fail_tap`=5.
- **Partial inject:** sweep with `inject` raised only during tap 3's CAPT cycles → `err_cnt`=4, `first_fail_tap`=3. Taps 4–7 add nothing.
- **Clamp/bypass:** `tap_sel`=15 with TAPS=8, `test`=0 → runs on tap 7, `err_cnt`=0. Launch value alternates across trials; `dout` matches it.
- **Handshake:** `start` pulsed while busy → ignored, `done` at original time. `start` in the `done` cycle → new run begins and results are cleared the next cycle.
